// File: rtl/icesugar_iomem_ctrl.sv
// -----------------------------------------------------------------------------
// icesugar_iomem_ctrl
//
// Bridges the picosoc iomem master port to up to four memory-mapped slaves.
// The window 0x03xx_xxxx is claimed and iomem_addr[23:20] selects the slot.
// Slots 0..3 go to real slaves. Slots 4..15 are answered at once with
// rdata 0 and they set the sticky bus_err flag. Addresses outside the window
// are never acknowledged.
//
// Ports
//   clk, resetn                 clock, synchronous active-low reset
//   iomem_valid/wstrb/addr/wdata  master request (a write when wstrb != 0)
//   iomem_ready, iomem_rdata    registered master response (ready: 1 cycle)
//   s_valid[3:0]                one-hot slave request, at most one bit high
//   s_wstrb, s_addr, s_wdata    slave request fields shared by all slots
//   s_ready[3:0], s_rdata[127:0]  slave responses, slot n in bits 32n+31:32n
//   bus_err                     sticky error flag, cleared only by reset
//
// Configuration
//   ICESUGAR_IOMEM_TIMEOUT_EN   when defined, an access that waits
//                               TIMEOUT_CYCLES cycles for the selected s_ready
//                               ends with rdata 0xDEAD_BEEF and sets bus_err.
//                               When undefined, ACCESS waits indefinitely.
// -----------------------------------------------------------------------------
module icesugar_iomem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         iomem_valid,
    input  logic [3:0]   iomem_wstrb,
    input  logic [31:0]  iomem_addr,
    input  logic [31:0]  iomem_wdata,
    output logic         iomem_ready,
    output logic [31:0]  iomem_rdata,
    output logic [3:0]   s_valid,
    output logic [3:0]   s_wstrb,
    output logic [31:0]  s_addr,
    output logic [31:0]  s_wdata,
    input  logic [3:0]   s_ready,
    input  logic [127:0] s_rdata,
    output logic         bus_err
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q, state_d;
    logic        hold_q, hold_d;
    logic [1:0]  slot_q, slot_d;
    logic [3:0]  s_valid_q, s_valid_d;
    logic [3:0]  s_wstrb_q, s_wstrb_d;
    logic [31:0] s_addr_q, s_addr_d;
    logic [31:0] s_wdata_q, s_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic        claim;
    logic        sel_ready;
    logic [31:0] sel_rdata;

`ifdef ICESUGAR_IOMEM_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign claim     = iomem_valid && (iomem_addr[31:24] == 8'h03);
    // Only the slot being served is ever looked at; other s_ready bits are dropped.
    assign sel_ready = s_ready[slot_q];
    assign sel_rdata = s_rdata[{slot_q, 5'b0} +: 32];

    always_comb begin
        state_d   = state_q;
        hold_d    = 1'b0;
        slot_d    = slot_q;
        s_wstrb_d = s_wstrb_q;
        s_addr_d  = s_addr_q;
        s_wdata_d = s_wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
`ifdef ICESUGAR_IOMEM_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif

        case (state_q)
            StIdle: begin
                // hold_q blocks the cycle right after RESP so the master can drop valid.
                if (claim && !hold_q) begin
                    s_addr_d  = iomem_addr;
                    s_wdata_d = iomem_wdata;
                    s_wstrb_d = iomem_wstrb;
                    if (iomem_addr[23:22] == 2'b00) begin
                        slot_d  = iomem_addr[21:20];
                        state_d = StAccess;
`ifdef ICESUGAR_IOMEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = StResp;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            StAccess: begin
                // A ready in the same cycle as the timeout takes priority.
                if (sel_ready) begin
                    rdata_d = sel_rdata;
                    state_d = StResp;
                end
`ifdef ICESUGAR_IOMEM_TIMEOUT_EN
                else if (cnt_q == TimeoutLast) begin
                    rdata_d = 32'hDEAD_BEEF;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            StResp: begin
                state_d = StIdle;
                hold_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        ready_d   = (state_d == StResp);
        s_valid_d = (state_d == StAccess) ? 4'(4'b0001 << slot_d) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= StIdle;
            hold_q    <= 1'b0;
            slot_q    <= 2'd0;
            s_valid_q <= 4'd0;
            s_wstrb_q <= 4'd0;
            s_addr_q  <= 32'd0;
            s_wdata_q <= 32'd0;
            rdata_q   <= 32'd0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef ICESUGAR_IOMEM_TIMEOUT_EN
            cnt_q     <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            slot_q    <= slot_d;
            s_valid_q <= s_valid_d;
            s_wstrb_q <= s_wstrb_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
`ifdef ICESUGAR_IOMEM_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign s_valid     = s_valid_q;
    assign s_wstrb     = s_wstrb_q;
    assign s_addr      = s_addr_q;
    assign s_wdata     = s_wdata_q;
    assign bus_err     = err_q;

endmodule

// File: tb/tb_icesugar_iomem_ctrl.sv
// -----------------------------------------------------------------------------
// Directed bench for icesugar_iomem_ctrl. Inputs change 1 time unit after a
// rising edge and outputs are checked at the same point, i.e. they show the
// registered result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_icesugar_iomem_ctrl;

    logic         clk = 1'b0;
    logic         resetn;
    logic         iomem_valid;
    logic [3:0]   iomem_wstrb;
    logic [31:0]  iomem_addr;
    logic [31:0]  iomem_wdata;
    logic         iomem_ready;
    logic [31:0]  iomem_rdata;
    logic [3:0]   s_valid;
    logic [3:0]   s_wstrb;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [3:0]   s_ready;
    logic [127:0] s_rdata;
    logic         bus_err;

    int tests = 0;
    int fails = 0;

    icesugar_iomem_ctrl #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_ready (iomem_ready),
        .iomem_rdata (iomem_rdata),
        .s_valid     (s_valid),
        .s_wstrb     (s_wstrb),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        iomem_valid = 1'b0;
        s_ready     = 4'b0000;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        int rdy_at;
        int sv_at;

        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;
        s_ready     = 4'b0000;
        s_rdata     = '0;
        tick();
        tick();
        tick();
        chk("rst_s_valid", {28'd0, s_valid}, 32'h0);
        chk("rst_ready", {31'd0, iomem_ready}, 32'h0);
        chk("rst_err", {31'd0, bus_err}, 32'h0);
        chk("rst_rdata", iomem_rdata, 32'h0);
        chk("rst_s_addr", s_addr, 32'h0);
        chk("rst_s_wdata", s_wdata, 32'h0);
        resetn = 1'b1;
        tick();

        // Write to slot 0, slave answers 2 cycles after s_valid.
        iomem_valid   = 1'b1;
        iomem_addr    = 32'h0300_0000;
        iomem_wdata   = 32'h0000_00A5;
        iomem_wstrb   = 4'hF;
        s_rdata[31:0] = 32'h0000_0011;
        tick();
        chk("wr_s_valid", {28'd0, s_valid}, 32'h1);
        chk("wr_s_wdata", s_wdata, 32'hA5);
        chk("wr_s_wstrb", {28'd0, s_wstrb}, 32'hF);
        chk("wr_s_addr", s_addr, 32'h0300_0000);
        chk("wr_ready_early", {31'd0, iomem_ready}, 32'h0);
        tick();
        chk("wr_s_valid_hold", {28'd0, s_valid}, 32'h1);
        s_ready = 4'b0001;
        tick();
        chk("wr_ready", {31'd0, iomem_ready}, 32'h1);
        chk("wr_s_valid_clr", {28'd0, s_valid}, 32'h0);
        chk("wr_rdata", iomem_rdata, 32'h11);
        chk("wr_err", {31'd0, bus_err}, 32'h0);
        iomem_valid = 1'b0;
        s_ready     = 4'b0000;
        tick();
        chk("wr_ready_pulse", {31'd0, iomem_ready}, 32'h0);
        tick();

        // Read slot 2 while slot 1 drives a stray ready.
        iomem_valid     = 1'b1;
        iomem_addr      = 32'h0320_0004;
        iomem_wstrb     = 4'h0;
        s_rdata[95:64]  = 32'h1234_5678;
        s_rdata[63:32]  = 32'hCAFE_F00D;
        s_ready         = 4'b0010;
        tick();
        chk("rd_s_valid", {28'd0, s_valid}, 32'h4);
        chk("rd_s_addr", s_addr, 32'h0320_0004);
        tick();
        chk("rd_stray_ignored", {31'd0, iomem_ready}, 32'h0);
        chk("rd_s_valid_hold", {28'd0, s_valid}, 32'h4);
        s_ready = 4'b0110;
        tick();
        chk("rd_ready", {31'd0, iomem_ready}, 32'h1);
        chk("rd_rdata", iomem_rdata, 32'h1234_5678);
        iomem_valid = 1'b0;
        s_ready     = 4'b0000;
        tick();
        tick();

        // Unpopulated slot 5: immediate response with rdata 0 and bus_err.
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0350_0000;
        tick();
        chk("bad_s_valid", {28'd0, s_valid}, 32'h0);
        chk("bad_ready", {31'd0, iomem_ready}, 32'h1);
        chk("bad_rdata", iomem_rdata, 32'h0);
        chk("bad_err", {31'd0, bus_err}, 32'h1);
        iomem_valid = 1'b0;
        tick();
        chk("bad_err_sticky", {31'd0, bus_err}, 32'h1);
        tick();

        // Outside the window: never acknowledged.
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0400_0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("unclaimed_ready", {31'd0, iomem_ready}, 32'h0);
            chk("unclaimed_s_valid", {28'd0, s_valid}, 32'h0);
        end
        iomem_valid = 1'b0;

        do_reset();
        chk("err_cleared", {31'd0, bus_err}, 32'h0);

`ifdef ICESUGAR_IOMEM_TIMEOUT_EN
        // Ready in the 4th ACCESS cycle coincides with the timeout: ready wins.
        iomem_valid      = 1'b1;
        iomem_addr       = 32'h0330_0000;
        s_rdata[127:96]  = 32'h0BAD_F00D;
        tick();
        chk("tw_s_valid", {28'd0, s_valid}, 32'h8);
        tick();
        tick();
        tick();
        chk("tw_s_valid_4th", {28'd0, s_valid}, 32'h8);
        s_ready = 4'b1000;
        tick();
        chk("tw_ready", {31'd0, iomem_ready}, 32'h1);
        chk("tw_rdata", iomem_rdata, 32'h0BAD_F00D);
        chk("tw_err", {31'd0, bus_err}, 32'h0);
        iomem_valid = 1'b0;
        s_ready     = 4'b0000;
        tick();
        tick();

        // Slot 3 never answers: timeout after 4 ACCESS cycles.
        iomem_valid = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("to_s_valid_held", {28'd0, s_valid}, 32'h8);
        chk("to_ready_early", {31'd0, iomem_ready}, 32'h0);
        tick();
        chk("to_s_valid_drop", {28'd0, s_valid}, 32'h0);
        chk("to_ready", {31'd0, iomem_ready}, 32'h1);
        chk("to_rdata", iomem_rdata, 32'hDEAD_BEEF);
        chk("to_err", {31'd0, bus_err}, 32'h1);
        iomem_valid = 1'b0;
        s_ready     = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_late_ready", {31'd0, iomem_ready}, 32'h0);
            chk("to_late_rdata", iomem_rdata, 32'hDEAD_BEEF);
        end
        s_ready = 4'b0000;
`else
        // Without the timeout, ACCESS waits as long as it takes.
        iomem_valid     = 1'b1;
        iomem_addr      = 32'h0330_0000;
        s_rdata[127:96] = 32'h0BAD_F00D;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("wait_s_valid", {28'd0, s_valid}, 32'h8);
            chk("wait_ready", {31'd0, iomem_ready}, 32'h0);
        end
        s_ready = 4'b1000;
        tick();
        chk("wait_done", {31'd0, iomem_ready}, 32'h1);
        chk("wait_rdata", iomem_rdata, 32'h0BAD_F00D);
        chk("wait_err", {31'd0, bus_err}, 32'h0);
        iomem_valid = 1'b0;
        s_ready     = 4'b0000;
        tick();
`endif
        tick();

        // Reset in the middle of an access to slot 1.
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0310_0000;
        tick();
        chk("ra_s_valid", {28'd0, s_valid}, 32'h2);
        tick();
        resetn  = 1'b0;
        s_ready = 4'b0010;
        tick();
        chk("ra_s_valid_clr", {28'd0, s_valid}, 32'h0);
        chk("ra_no_ready", {31'd0, iomem_ready}, 32'h0);
        resetn      = 1'b1;
        iomem_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("ra_late_ready", {31'd0, iomem_ready}, 32'h0);
        end
        s_ready       = 4'b0000;
        iomem_valid   = 1'b1;
        iomem_addr    = 32'h0300_0000;
        s_rdata[31:0] = 32'h5A5A_0001;
        tick();
        chk("ra_rd_s_valid", {28'd0, s_valid}, 32'h1);
        s_ready = 4'b0001;
        tick();
        chk("ra_rd_ready", {31'd0, iomem_ready}, 32'h1);
        chk("ra_rd_rdata", iomem_rdata, 32'h5A5A_0001);
        iomem_valid = 1'b0;
        s_ready     = 4'b0000;
        tick();
        tick();

        // Back-to-back with valid held and slave 0 always ready:
        // ACCESS, RESP, IDLE(hold), IDLE(accept), repeating every 4 cycles.
        iomem_valid   = 1'b1;
        iomem_addr    = 32'h0300_0010;
        s_ready       = 4'b0001;
        s_rdata[31:0] = 32'h0000_0B2B;
        rdy_at = -1;
        sv_at  = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("b2b_s_valid", {28'd0, s_valid}, ((i - 1) % 4 == 0) ? 32'h1 : 32'h0);
            chk("b2b_ready", {31'd0, iomem_ready}, ((i - 1) % 4 == 1) ? 32'h1 : 32'h0);
            chk("b2b_onehot", $countones(s_valid), 32'(s_valid != 4'b0000));
            if (iomem_ready && rdy_at < 0) rdy_at = i;
            if (s_valid != 4'b0000 && rdy_at >= 0 && sv_at < 0) sv_at = i;
        end
        chk("b2b_gap", 32'(sv_at - rdy_at), 32'd3);
        iomem_valid = 1'b0;
        s_ready     = 4'b0000;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/icesugar_iomem_ctrl.md
ICESUGAR_IOMEM_CTRL -- requirements
Module: icesugar_iomem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: the maximum number of cycles to wait for a slave response (range 1..65535).
REQ-002 SHALL have port clk, input, 1: the clock; all logic is on its rising edge.
REQ-003 SHALL have port resetn, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have ports iomem_valid (in, 1), iomem_wstrb (in, 4), iomem_addr (in, 32), iomem_wdata (in, 32): the picosoc iomem master request.
REQ-005 SHALL have ports iomem_ready (out, 1) and iomem_rdata (out, 32): the master response; both are registered.
REQ-006 SHALL have ports s_valid (out, 4), s_wstrb (out, 4), s_addr (out, 32), s_wdata (out, 32): the slave request, one valid bit per slot; the strobe, address and data are shared by all slots.
REQ-007 SHALL have ports s_ready (in, 4) and s_rdata (in, 128): the slave responses; slot n read data is in s_rdata[32n+31:32n].
REQ-008 SHALL have port bus_err (out, 1): a sticky error flag.

Function
REQ-009 SHALL claim a request only when iomem_addr[31:24]==8'h03; the slot is iomem_addr[23:20].
- Requests outside that region are never acknowledged by this block.
REQ-010 SHALL implement the states IDLE, ACCESS, RESP.
REQ-011 In IDLE, with iomem_valid and a claimed address, SHALL register the address, write data, strobe and slot.
- Slot 0..3: the next state is ACCESS, and s_valid[slot] is 1 from the next cycle.
- Slot 4..15: the next state is RESP, iomem_rdata is 0 and bus_err is set.
REQ-012 In ACCESS, s_valid[slot] SHALL remain 1 and all s_addr/s_wdata/s_wstrb SHALL be held stable until the selected s_ready is sampled as 1.
REQ-013 On the selected s_ready==1 in ACCESS, SHALL capture that slot's s_rdata into iomem_rdata, clear s_valid and go to RESP.
REQ-014 s_ready from a non-selected slot SHALL be ignored in every state.
REQ-015 In RESP, iomem_ready SHALL be 1 for exactly that one cycle; the next state is IDLE.
- Latency: the cycle after the selected s_ready is sampled high.
REQ-016 After RESP, SHALL not accept a new request in the IDLE cycle that follows, so the master has one cycle to drop iomem_valid.
- The earliest new s_valid is 3 cycles after iomem_ready.
REQ-017 At most one s_valid bit SHALL be 1 at any time.
REQ-018 s_valid SHALL be 0 in IDLE and in RESP.
REQ-019 Write versus read is defined by iomem_wstrb!=0; for writes, iomem_rdata is still the captured s_rdata.
REQ-020 A timeout counter SHALL clear on entry to ACCESS and increment each ACCESS cycle.
- When it reaches TIMEOUT_CYCLES without the selected s_ready: clear s_valid, load iomem_rdata with 32'hDEAD_BEEF, set bus_err, go to RESP.
- If the selected s_ready arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the ready wins: normal capture, bus_err is not set.
- A late s_ready after a timeout is ignored.
REQ-021 bus_err SHALL remain 1 once set, until reset.

Reset
REQ-022 While resetn==0 at a clock edge, SHALL set the following, regardless of any in-flight access:
- state to IDLE
- s_valid, iomem_ready and bus_err to 0
- iomem_rdata, s_addr, s_wdata, s_wstrb to 0
- the timeout counter to 0
REQ-023 An access aborted by reset SHALL never produce iomem_ready; any slave response that arrives afterwards is ignored.

Configuration
REQ-024 Macro ICESUGAR_IOMEM_TIMEOUT_EN SHALL control the timeout.
- Defined: REQ-020 applies.
- Undefined: the counter is not synthesized, ACCESS waits indefinitely for s_ready, and bus_err is set only by REQ-011 (slots 4..15).

Verification
REQ-025 Write 0x0300_0000, wdata 0x0000_00A5, wstrb 4'hF; slave 0 is ready 2 cycles after s_valid -> s_valid==4'b0001 with s_wdata 0xA5, then iomem_ready one cycle after s_ready, bus_err==0.
REQ-026 Read 0x0320_0004; slave 2 returns 0x1234_5678 -> iomem_rdata==0x1234_5678 while iomem_ready==1; s_ready[1] pulsed at the same time has no effect.
REQ-027 Read 0x0350_0000 -> no s_valid; iomem_ready 1 cycle later with rdata 0; bus_err==1.
REQ-028 With the macro defined, TIMEOUT_CYCLES=4, slot 3 never ready -> s_valid[3] drops after 4 ACCESS cycles, iomem_rdata==0xDEAD_BEEF, bus_err==1; a later s_ready[3] is ignored.
REQ-029 Reset asserted during ACCESS on slot 1 -> next cycle s_valid==0 and no iomem_ready; after release, a read to 0x0300_0000 completes normally.
REQ-030 Back-to-back requests with iomem_valid held through RESP -> the second s_valid is no earlier than 3 cycles after the first iomem_ready; at no time is more than one s_valid bit high.
